// File: rtl/rank_match_scheduler.sv
// Rank classification sequencer: streams every rank template against the captured corner
// mask through one shared XOR datapath and reports the lowest-mismatch template.
module rank_match_scheduler #(
    parameter int CORNER_W      = 28,
    parameter int RANK_H        = 40,
    parameter int NUM_TEMPLATES = 13,
    parameter int READ_LAT      = 2,
    parameter int MATCH_THRESH  = 300,
    localparam int RANK_SIZE    = CORNER_W * RANK_H,
    localparam int PIX_W        = $clog2(RANK_SIZE),
    localparam int TADDR_W      = $clog2(NUM_TEMPLATES * RANK_SIZE),
    localparam int SCORE_W      = $clog2(RANK_SIZE + 1),
    localparam int IDX_W        = $clog2(NUM_TEMPLATES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PIX_W-1:0]   mask_addr,
    output logic [TADDR_W-1:0] tmpl_addr,
    input  logic               mask_data,
    input  logic               tmpl_data,
    output logic               busy,
    output logic               tmpl_score_valid,
    output logic [IDX_W-1:0]   tmpl_idx,
    output logic [SCORE_W-1:0] tmpl_score,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic               match
);

    localparam int N_TOTAL = NUM_TEMPLATES * RANK_SIZE;
    localparam int DRAIN_W = $clog2(READ_LAT + 1);

    localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(RANK_SIZE - 1);
    localparam logic [TADDR_W-1:0] ADDR_LAST  = TADDR_W'(N_TOTAL - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LAT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(RANK_SIZE);
    localparam logic [SCORE_W-1:0] THRESH     = SCORE_W'(MATCH_THRESH);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_TEMPLATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    logic [PIX_W-1:0]   pix;
    logic [IDX_W-1:0]   idx;
    logic [DRAIN_W-1:0] drain_cnt;

    // Tags travel alongside the outstanding reads so each returned pixel knows its template.
    logic [READ_LAT-1:0] tag_valid;
    logic [READ_LAT-1:0] tag_last;
    logic [IDX_W-1:0]    tag_idx [READ_LAT];

    logic               sample_valid;
    logic               sample_last;
    logic [IDX_W-1:0]   sample_idx;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] acc_next;
    logic [SCORE_W-1:0] run_min;
    logic [IDX_W-1:0]   run_idx;
    logic               new_lt;
    logic [SCORE_W-1:0] min_score_next;
    logic [IDX_W-1:0]   min_idx_next;

    assign mask_addr    = pix;
    assign sample_valid = tag_valid[READ_LAT-1];
    assign sample_last  = tag_last[READ_LAT-1];
    assign sample_idx   = tag_idx[READ_LAT-1];

    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use <= only, so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            pix       <= '0;
            idx       <= '0;
            tmpl_addr <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (tmpl_addr == ADDR_LAST) begin
                        state     <= S_DRAIN;
                        pix       <= '0;
                        idx       <= '0;
                        tmpl_addr <= '0;
                        drain_cnt <= '0;
                    end else begin
                        tmpl_addr <= tmpl_addr + TADDR_W'(1);
                        if (pix == PIX_LAST) begin
                            pix <= '0;
                            idx <= idx + IDX_W'(1);
                        end else begin
                            pix <= pix + PIX_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a signal unassigned.
        acc_next = acc;
        if ((mask_data ^ tmpl_data) && (acc != SCORE_MAX)) begin
            acc_next = acc + SCORE_W'(1);
        end
        new_lt         = acc_next < run_min;
        min_score_next = new_lt ? acc_next : run_min;
        min_idx_next   = new_lt ? sample_idx : run_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tag pipe is reset so reads still in flight after an abort are discarded.
            tag_valid <= '0;
            tag_last  <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_idx[i] <= '0;
            end
            acc              <= '0;
            run_min          <= '0;
            run_idx          <= '0;
            tmpl_score_valid <= 1'b0;
            tmpl_idx         <= '0;
            tmpl_score       <= '0;
            best_idx         <= '0;
            best_score       <= '0;
            match            <= 1'b0;
        end else begin
            tag_valid[0] <= (state == S_ISSUE);
            tag_last[0]  <= (state == S_ISSUE) && (pix == PIX_LAST);
            tag_idx[0]   <= idx;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
                tag_idx[i]   <= tag_idx[i-1];
            end

            tmpl_score_valid <= 1'b0;

            if ((state == S_IDLE) && start) begin
                acc     <= '0;
                run_min <= SCORE_MAX;
                run_idx <= '0;
            end

            if (sample_valid) begin
                if (sample_last) begin
                    acc              <= '0;
                    tmpl_score_valid <= 1'b1;
                    tmpl_idx         <= sample_idx;
                    tmpl_score       <= acc_next;
                    run_min          <= min_score_next;
                    run_idx          <= min_idx_next;
                    // Final template: publish the result so it is visible in the done cycle.
                    if (sample_idx == IDX_LAST) begin
                        best_idx   <= min_idx_next;
                        best_score <= min_score_next;
                        match      <= (min_score_next <= THRESH);
                    end
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Directed bench for rank_match_scheduler: behavioural mask/template memories with a
// two-cycle read latency and templates built to hit hand-chosen mismatch scores.
module tb_rank_match_scheduler;

    localparam int RS   = 1120;
    localparam int NT   = 13;
    localparam int NTOT = NT * RS;
    localparam int RL   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] mask_addr;
    logic [13:0] tmpl_addr;
    logic        mask_data;
    logic        tmpl_data;
    logic        busy;
    logic        tmpl_score_valid;
    logic [3:0]  tmpl_idx;
    logic [10:0] tmpl_score;
    logic        done;
    logic [3:0]  best_idx;
    logic [10:0] best_score;
    logic        match;

    rank_match_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .mask_addr        (mask_addr),
        .tmpl_addr        (tmpl_addr),
        .mask_data        (mask_data),
        .tmpl_data        (tmpl_data),
        .busy             (busy),
        .tmpl_score_valid (tmpl_score_valid),
        .tmpl_idx         (tmpl_idx),
        .tmpl_score       (tmpl_score),
        .done             (done),
        .best_idx         (best_idx),
        .best_score       (best_score),
        .match            (match)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit mask_mem [RS];
    bit tmpl_mem [NTOT];
    bit m_d1, m_d2, t_d1, t_d2;

    always @(posedge clk) begin
        m_d1 <= mask_mem[int'(mask_addr)];
        m_d2 <= m_d1;
        t_d1 <= tmpl_mem[int'(tmpl_addr)];
        t_d2 <= t_d1;
    end
    assign mask_data = m_d2;
    assign tmpl_data = t_d2;

    int compared   = 0;
    int mismatched = 0;

    int sv_cnt, done_cnt, done_cyc, last_busy_cyc, addr_err, t0;
    bit addr_chk = 1'b0;
    int sv_idx [16];
    int sv_score [16];
    int sv_cyc [16];

    always @(negedge clk) begin
        if (tmpl_score_valid) begin
            if (sv_cnt < 16) begin
                sv_idx[sv_cnt]   = int'(tmpl_idx);
                sv_score[sv_cnt] = int'(tmpl_score);
                sv_cyc[sv_cnt]   = cyc;
            end
            sv_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) last_busy_cyc = cyc;
        if (addr_chk) begin
            if (cyc >= t0 + 1 && cyc <= t0 + NTOT) begin
                if (int'(tmpl_addr) != cyc - t0 - 1 || int'(mask_addr) != (cyc - t0 - 1) % RS)
                    addr_err++;
            end else if (tmpl_addr != 0 || mask_addr != 0) begin
                addr_err++;
            end
        end
    end

    task automatic load(input bit zero_mask, input int k [NT]);
        for (int p = 0; p < RS; p++)
            mask_mem[p] = zero_mask ? 1'b0 : bit'($urandom_range(0, 1));
        for (int t = 0; t < NT; t++)
            for (int p = 0; p < RS; p++)
                tmpl_mem[t*RS + p] = mask_mem[p] ^ (p < k[t]);
    endtask

    task automatic clear_mon();
        sv_cnt = 0; done_cnt = 0; addr_err = 0; done_cyc = -1; last_busy_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            sv_idx[i] = -1; sv_score[i] = -1; sv_cyc[i] = -1;
        end
    endtask

    task automatic launch(input bit chk);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        addr_chk = chk;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        timed_out = busy;
        repeat (3) @(negedge clk);
        addr_chk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, done, tmpl_score_valid, match} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, tmpl_score_valid, match});
        end
        compared++;
        if ({tmpl_idx, tmpl_score, best_idx, best_score} !== 30'b0) begin
            mismatched++;
            $display("FAIL reset_values: got %h expected 0", {tmpl_idx, tmpl_score, best_idx, best_score});
        end
        compared++;
        if ({mask_addr, tmpl_addr} !== 25'b0) begin
            mismatched++;
            $display("FAIL reset_addr: got %h expected 0", {mask_addr, tmpl_addr});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_exact_match();
        int k [NT] = '{50, 60, 70, 80, 90, 0, 55, 65, 75, 85, 95, 100, 110};
        bit to;
        load(1'b0, k);
        clear_mon();
        while (cyc < 99) @(negedge clk);
        launch(1'b1);
        wait_idle(to);
        compared++;
        if (to) begin mismatched++; $display("FAIL exact_timeout: busy still %b expected 0", busy); end
        compared++;
        if (sv_cnt !== NT) begin mismatched++; $display("FAIL exact_pulses: got %0d expected %0d", sv_cnt, NT); end
        for (int i = 0; i < NT; i++) begin
            compared++;
            if (sv_idx[i] !== i || sv_score[i] !== k[i]) begin
                mismatched++;
                $display("FAIL exact_score[%0d]: got idx %0d score %0d expected idx %0d score %0d",
                         i, sv_idx[i], sv_score[i], i, k[i]);
            end
        end
        compared++;
        if (sv_cyc[0] !== 1223) begin mismatched++; $display("FAIL exact_first_pulse_cycle: got %0d expected 1223", sv_cyc[0]); end
        compared++;
        if (done_cnt !== 1 || done_cyc !== 14663) begin
            mismatched++;
            $display("FAIL exact_done: got count %0d cycle %0d expected count 1 cycle 14663", done_cnt, done_cyc);
        end
        compared++;
        if (sv_cyc[NT-1] !== 14663) begin mismatched++; $display("FAIL exact_last_pulse_cycle: got %0d expected 14663", sv_cyc[NT-1]); end
        compared++;
        if (last_busy_cyc !== 14663) begin mismatched++; $display("FAIL exact_busy_end: got %0d expected 14663", last_busy_cyc); end
        compared++;
        if (addr_err !== 0) begin mismatched++; $display("FAIL exact_addr_seq: got %0d bad cycles expected 0", addr_err); end
        compared++;
        if (best_idx !== 4'd5 || best_score !== 11'd0 || match !== 1'b1) begin
            mismatched++;
            $display("FAIL exact_best: got idx %0d score %0d match %b expected 5 0 1", best_idx, best_score, match);
        end
    endtask

    task automatic test_ties_ignored_start();
        int k [NT] = '{30, 40, 50, 12, 60, 70, 80, 12, 90, 100, 110, 120, 130};
        bit to;
        load(1'b0, k);
        clear_mon();
        launch(1'b0);
        while (cyc < t0 + 500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + NTOT + RL + 1) @(negedge clk);
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("FAIL ties_done_cycle: got %b expected 1", done); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL ties_start_in_done: busy got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL ties_stay_idle: busy got %b expected 0", busy); end
        wait_idle(to);
        compared++;
        if (to) begin mismatched++; $display("FAIL ties_timeout: busy still %b expected 0", busy); end
        compared++;
        if (done_cnt !== 1 || done_cyc !== t0 + NTOT + RL + 1) begin
            mismatched++;
            $display("FAIL ties_single_done: got count %0d cycle %0d expected 1 %0d", done_cnt, done_cyc, t0 + NTOT + RL + 1);
        end
        compared++;
        if (sv_cnt !== NT) begin mismatched++; $display("FAIL ties_pulses: got %0d expected %0d", sv_cnt, NT); end
        for (int i = 0; i < NT; i++) begin
            compared++;
            if (sv_idx[i] !== i || sv_score[i] !== k[i]) begin
                mismatched++;
                $display("FAIL ties_score[%0d]: got idx %0d score %0d expected idx %0d score %0d",
                         i, sv_idx[i], sv_score[i], i, k[i]);
            end
        end
        compared++;
        if (best_idx !== 4'd3 || best_score !== 11'd12 || match !== 1'b1) begin
            mismatched++;
            $display("FAIL ties_best: got idx %0d score %0d match %b expected 3 12 1", best_idx, best_score, match);
        end
    endtask

    task automatic test_saturation();
        int k [NT] = '{1120, 500, 500, 500, 500, 500, 500, 500, 500, 400, 500, 500, 500};
        bit to;
        load(1'b1, k);
        clear_mon();
        launch(1'b1);
        wait_idle(to);
        compared++;
        if (to) begin mismatched++; $display("FAIL sat_timeout: busy still %b expected 0", busy); end
        compared++;
        if (sv_score[0] !== 1120 || sv_idx[0] !== 0) begin
            mismatched++;
            $display("FAIL sat_full_mismatch: got idx %0d score %0d expected idx 0 score 1120", sv_idx[0], sv_score[0]);
        end
        for (int i = 1; i < NT; i++) begin
            compared++;
            if (sv_idx[i] !== i || sv_score[i] !== k[i]) begin
                mismatched++;
                $display("FAIL sat_score[%0d]: got idx %0d score %0d expected idx %0d score %0d",
                         i, sv_idx[i], sv_score[i], i, k[i]);
            end
        end
        compared++;
        if (best_idx !== 4'd9 || best_score !== 11'd400 || match !== 1'b0) begin
            mismatched++;
            $display("FAIL sat_best: got idx %0d score %0d match %b expected 9 400 0", best_idx, best_score, match);
        end
        compared++;
        if (done_cnt !== 1 || addr_err !== 0) begin
            mismatched++;
            $display("FAIL sat_done_addr: got done %0d addr_err %0d expected 1 0", done_cnt, addr_err);
        end
    endtask

    task automatic test_reset_abort();
        int k [NT] = '{310, 311, 312, 313, 314, 315, 316, 317, 318, 319, 320, 321, 300};
        int n_before;
        load(1'b0, k);
        clear_mon();
        launch(1'b0);
        while (cyc < t0 + 3000) @(negedge clk);
        n_before = sv_cnt;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, done, tmpl_score_valid, match} !== 4'b0) begin
            mismatched++;
            $display("FAIL abort_flags: got %b expected 0000", {busy, done, tmpl_score_valid, match});
        end
        compared++;
        if ({tmpl_idx, tmpl_score, best_idx, best_score} !== 30'b0) begin
            mismatched++;
            $display("FAIL abort_values: got %h expected 0", {tmpl_idx, tmpl_score, best_idx, best_score});
        end
        compared++;
        if ({mask_addr, tmpl_addr} !== 25'b0) begin
            mismatched++;
            $display("FAIL abort_addr: got %h expected 0", {mask_addr, tmpl_addr});
        end
        rst = 1'b0;
        repeat (40) @(negedge clk);
        compared++;
        if (sv_cnt !== n_before || done_cnt !== 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_quiet: got pulses %0d done %0d busy %b expected %0d 0 0",
                     sv_cnt, done_cnt, busy, n_before);
        end
    endtask

    task automatic test_after_reset();
        int k [NT] = '{310, 311, 312, 313, 314, 315, 316, 317, 318, 319, 320, 321, 300};
        bit to;
        clear_mon();
        launch(1'b1);
        wait_idle(to);
        compared++;
        if (to) begin mismatched++; $display("FAIL rerun_timeout: busy still %b expected 0", busy); end
        compared++;
        if (sv_cnt !== NT) begin mismatched++; $display("FAIL rerun_pulses: got %0d expected %0d", sv_cnt, NT); end
        for (int i = 0; i < NT; i++) begin
            compared++;
            if (sv_idx[i] !== i || sv_score[i] !== k[i]) begin
                mismatched++;
                $display("FAIL rerun_score[%0d]: got idx %0d score %0d expected idx %0d score %0d",
                         i, sv_idx[i], sv_score[i], i, k[i]);
            end
        end
        compared++;
        if (best_idx !== 4'd12 || best_score !== 11'd300 || match !== 1'b1) begin
            mismatched++;
            $display("FAIL rerun_best: got idx %0d score %0d match %b expected 12 300 1", best_idx, best_score, match);
        end
        compared++;
        if (done_cnt !== 1 || done_cyc !== t0 + NTOT + RL + 1 || addr_err !== 0) begin
            mismatched++;
            $display("FAIL rerun_done_addr: got done %0d cycle %0d addr_err %0d expected 1 %0d 0",
                     done_cnt, done_cyc, addr_err, t0 + NTOT + RL + 1);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_exact_match();
        test_ties_ignored_start();
        test_saturation();
        test_reset_abort();
        test_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
